// File: rtl/f_pc_fetch.sv
// f_pc_fetch: fetch-stage PC register, single-outstanding instruction fetch
// engine and IF/ID pipeline register, with a one-entry stall hold buffer and
// redirect handling that drains an abandoned in-flight fetch.
module f_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_addr_nextpc,
    input  logic        i_con_redirect,
    input  logic        i_con_stall,
    output logic [31:0] o_addr_pcplus4,
    output logic [31:0] o_addr_pc,

    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,

    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pcplus4,
    output logic        o_ifid_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] RESET_PC_ALGN = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Architectural state
    state_t            state_q,        state_d;
    logic [XLEN-1:0]   pc_q,           pc_d;
    logic [XLEN-1:0]   drain_addr_q,   drain_addr_d;
    logic [XLEN-1:0]   hold_instr_q,   hold_instr_d;
    logic [XLEN-1:0]   hold_pcplus4_q, hold_pcplus4_d;
    logic [XLEN-1:0]   ifid_instr_q,   ifid_instr_d;
    logic [XLEN-1:0]   ifid_pcplus4_q, ifid_pcplus4_d;
    logic              ifid_valid_q,   ifid_valid_d;

    // Registered memory-port outputs, derived from next state
    logic              imem_req_q,     imem_req_d;
    logic [XLEN-1:0]   imem_addr_q,    imem_addr_d;

    // Derived values
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   nextpc_algn;

    // Sequential-path adder and aligned mux input
    always_comb begin
        pc_plus4    = pc_q + PC_STEP;
        nextpc_algn = i_addr_nextpc & ALIGN_MASK;
    end

    // Next-state and next-register computation; redirect takes priority
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_addr_d   = drain_addr_q;
        hold_instr_d   = hold_instr_q;
        hold_pcplus4_d = hold_pcplus4_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;

        if (i_con_redirect) begin
            pc_d           = nextpc_algn;
            ifid_valid_d   = 1'b0;
            hold_instr_d   = '0;
            hold_pcplus4_d = '0;
            case (state_q)
                ST_FETCH: begin
                    // An unacknowledged fetch must still complete on its old address
                    if (!i_imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = ST_DRAIN;
                    end else begin
                        state_d      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_DRAIN;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end

                ST_FETCH: begin
                    if (i_imem_ack && !i_con_stall) begin
                        ifid_instr_d   = i_imem_rdata;
                        ifid_pcplus4_d = pc_plus4;
                        ifid_valid_d   = 1'b1;
                        pc_d           = nextpc_algn;
                    end else if (i_imem_ack) begin
                        // ID is stalled: park the returned word until it frees up
                        hold_instr_d   = i_imem_rdata;
                        hold_pcplus4_d = pc_plus4;
                        state_d        = ST_HOLD;
                    end else if (!i_con_stall) begin
                        ifid_valid_d   = 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (!i_con_stall) begin
                        ifid_instr_d   = hold_instr_q;
                        ifid_pcplus4_d = hold_pcplus4_q;
                        ifid_valid_d   = 1'b1;
                        pc_d           = nextpc_algn;
                        state_d        = ST_FETCH;
                    end
                end

                ST_DRAIN: begin
                    ifid_valid_d = 1'b0;
                    if (i_imem_ack) begin
                        state_d = ST_FETCH;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        imem_req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        imem_addr_d = (state_d == ST_DRAIN) ? drain_addr_d : pc_d;
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC_ALGN;
            drain_addr_q   <= '0;
            hold_instr_q   <= '0;
            hold_pcplus4_q <= '0;
            ifid_instr_q   <= '0;
            ifid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_PC_ALGN;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            drain_addr_q   <= drain_addr_d;
            hold_instr_q   <= hold_instr_d;
            hold_pcplus4_q <= hold_pcplus4_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
        end
    end

    // Output wiring; PC+4 is combinational because the PC mux needs it this cycle
    always_comb begin
        o_addr_pcplus4 = pc_plus4;
        o_addr_pc      = pc_q;
        o_imem_req     = imem_req_q;
        o_imem_addr    = imem_addr_q;
        o_ifid_instr   = ifid_instr_q;
        o_ifid_pcplus4 = ifid_pcplus4_q;
        o_ifid_valid   = ifid_valid_q;
    end

endmodule
